// File: rtl/rtc_pkg.sv
// Shared time-of-day constants and the 24h-to-12h display helper.
package rtc_pkg;

    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;

    localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
    localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
    localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;

    // Maps 0..23 to 1..12; midnight and noon both show as 12.
    function automatic logic [HOUR_W-1:0] to_12h(input logic [HOUR_W-1:0] h24);
        logic [HOUR_W-1:0] r;
        r = (h24 >= 5'd12) ? h24 - 5'd12 : h24;
        if (r == '0) begin
            r = 5'd12;
        end
        return r;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICKS_PER_SEC enabled cycles.
module tick_prescaler #(
    parameter int TICKS_PER_SEC = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICKS_PER_SEC - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // clr restarts the phase so a freshly loaded time lasts a full second.
    always_comb begin
        tick  = en && (cnt_q == CNT_LAST);
        cnt_d = cnt_q;
        if (clr || tick) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rtc_clock_core.sv
// Real-time clock: prescaled H:M:S counter with time-set handshake,
// 12/24h display, alarm and day-wrap pulses. Time is stored in 24h form.
module rtc_clock_core
    import rtc_pkg::*;
#(
    parameter int TICKS_PER_SEC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              mode_24,
    input  logic              set_valid,
    output logic              set_ready,
    input  logic [HOUR_W-1:0] set_hours,
    input  logic [MIN_W-1:0]  set_minutes,
    input  logic [SEC_W-1:0]  set_seconds,
    output logic              set_err,
    input  logic              alarm_en,
    input  logic [HOUR_W-1:0] alarm_hours,
    input  logic [MIN_W-1:0]  alarm_minutes,
    output logic [SEC_W-1:0]  seconds,
    output logic [MIN_W-1:0]  minutes,
    output logic [HOUR_W-1:0] hours,
    output logic              pm,
    output logic              sec_tick,
    output logic              day_wrap,
    output logic              alarm
);

    logic [SEC_W-1:0]  sec_q, sec_d;
    logic [MIN_W-1:0]  min_q, min_d;
    logic [HOUR_W-1:0] hour_q, hour_d;
    logic set_ready_q, set_ready_d;
    logic set_err_q, set_err_d;
    logic sec_tick_q, sec_tick_d;
    logic day_wrap_q, day_wrap_d;
    logic alarm_q, alarm_d;

    logic tick;
    logic accept;
    logic load_ok;
    logic load;

    assign accept  = set_valid && set_ready_q;
    assign load_ok = (set_hours <= HOUR_MAX) && (set_minutes <= MIN_MAX) &&
                     (set_seconds <= SEC_MAX);
    assign load    = accept && load_ok;

    tick_prescaler #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (load),
        .tick (tick)
    );

    // A valid load overrides a coincident tick; an invalid one leaves the tick alone.
    always_comb begin
        sec_d       = sec_q;
        min_d       = min_q;
        hour_d      = hour_q;
        sec_tick_d  = 1'b0;
        day_wrap_d  = 1'b0;
        alarm_d     = 1'b0;
        set_ready_d = !accept;
        set_err_d   = accept && !load_ok;
        if (load) begin
            sec_d  = set_seconds;
            min_d  = set_minutes;
            hour_d = set_hours;
        end else if (tick) begin
            sec_tick_d = 1'b1;
            if (sec_q != SEC_MAX) begin
                sec_d = sec_q + SEC_W'(1);
            end else begin
                sec_d = '0;
                if (min_q != MIN_MAX) begin
                    min_d = min_q + MIN_W'(1);
                end else begin
                    min_d = '0;
                    if (hour_q != HOUR_MAX) begin
                        hour_d = hour_q + HOUR_W'(1);
                    end else begin
                        hour_d     = '0;
                        day_wrap_d = 1'b1;
                    end
                end
            end
            alarm_d = alarm_en && (sec_d == '0) && (min_d == alarm_minutes) &&
                      (hour_d == alarm_hours);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sec_q       <= '0;
            min_q       <= '0;
            hour_q      <= '0;
            set_ready_q <= 1'b0;
            set_err_q   <= 1'b0;
            sec_tick_q  <= 1'b0;
            day_wrap_q  <= 1'b0;
            alarm_q     <= 1'b0;
        end else begin
            sec_q       <= sec_d;
            min_q       <= min_d;
            hour_q      <= hour_d;
            set_ready_q <= set_ready_d;
            set_err_q   <= set_err_d;
            sec_tick_q  <= sec_tick_d;
            day_wrap_q  <= day_wrap_d;
            alarm_q     <= alarm_d;
        end
    end

    assign seconds   = sec_q;
    assign minutes   = min_q;
    assign hours     = mode_24 ? hour_q : to_12h(hour_q);
    assign pm        = (hour_q >= 5'd12);
    assign set_ready = set_ready_q;
    assign set_err   = set_err_q;
    assign sec_tick  = sec_tick_q;
    assign day_wrap  = day_wrap_q;
    assign alarm     = alarm_q;

endmodule
